lane_event_collector: RTL and testbench

- Downstream consumer of an array of single-bit interface lanes; the parent's generate loop flattens each lane's `a` field into `lane_a[i]`.
- Detects rising edges per lane and latches them as pending events.
- Serializes pending events round-robin onto one valid/ready output stream of lane indices.
- Counts events lost to re-triggering of an already-pending lane.

---
 rtl/lane_event_collector_pkg.sv | 15 +
 rtl/lane_event_collector_arb.sv | 36 +++
 rtl/lane_event_collector.sv | 140 ++++++++++++++
 tb/tb_lane_event_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_event_collector_pkg.sv
// Shared types and helpers for the lane event collector.
// Timestamp support is built only when LANE_EVENT_COLLECTOR_TSTAMP_EN is defined.
package lane_event_pkg;

    localparam int MAX_LANES = 32;
    localparam int TS_W      = 16;

    function automatic int LANE_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [LANE_IDX_W(MAX_LANES)-1:0] lane_idx_t;
    typedef logic [TS_W-1:0]                  ts_t;

endpackage

// File: rtl/lane_event_collector_arb.sv
// Combinational round-robin pick over a request bitmap.
// Search starts at i_rr_ptr and wraps from N-1 back to 0.
module lane_rr_arbiter
    import lane_event_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = LANE_IDX_W(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any_grant
);

    int w_j;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_j         = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_rr_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!o_any_grant && i_req[w_j]) begin
                o_any_grant    = 1'b1;
                o_grant[w_j]   = 1'b1;
                o_grant_idx    = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/lane_event_collector.sv
// Rising-edge collector: latches per-lane events, serializes them round-robin.
// Define LANE_EVENT_COLLECTOR_TSTAMP_EN to add per-event 16-bit timestamps (evt_ts).
module lane_event_collector
    import lane_event_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int DROP_W  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_LANES-1:0]                lane_a,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [LANE_IDX_W(N_LANES)-1:0]    evt_lane,
    output logic [N_LANES-1:0]                pending,
    output logic [DROP_W-1:0]                 drop_cnt
`ifdef LANE_EVENT_COLLECTOR_TSTAMP_EN
    ,
    output ts_t                               evt_ts
`endif
);

    localparam int IW = LANE_IDX_W(N_LANES);
    localparam int SW = DROP_W + 6;

    logic [N_LANES-1:0] r_lane_q;
    logic [N_LANES-1:0] r_pending;
    logic               r_valid;
    logic [IW-1:0]      r_lane;
    logic [IW-1:0]      r_rr_ptr;
    logic [DROP_W-1:0]  r_drop;

    logic [N_LANES-1:0] w_edge;
    logic               w_load;
    logic [N_LANES-1:0] w_arb_grant;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic [N_LANES-1:0] w_gnt;
    logic [N_LANES-1:0] w_drop;
    logic [5:0]         w_drop_n;
    logic [SW-1:0]      w_drop_sum;
    logic [DROP_W-1:0]  w_drop_next;
    logic [IW-1:0]      w_rr_next;

    assign w_edge = lane_a & ~r_lane_q;
    assign w_load = ~r_valid | evt_ready;

    lane_rr_arbiter #(
        .N  (N_LANES),
        .IW (IW)
    ) u_arb (
        .i_req       (r_pending),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_any_grant (w_arb_any)
    );

    // A grant only happens when the output register can take a new event.
    assign w_gnt  = w_load ? w_arb_grant : '0;
    assign w_drop = w_edge & r_pending & ~w_gnt;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_drop_n = w_drop_n + 6'(w_drop[i]);
        end
    end

    assign w_drop_sum  = SW'(r_drop) + SW'(w_drop_n);
    assign w_drop_next = (w_drop_sum > SW'({DROP_W{1'b1}}))
                       ? {DROP_W{1'b1}}
                       : w_drop_sum[DROP_W-1:0];

    assign w_rr_next = (w_arb_idx == IW'(N_LANES - 1))
                     ? '0
                     : w_arb_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_q  <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_lane    <= '0;
            r_rr_ptr  <= '0;
            r_drop    <= '0;
        end else begin
            r_lane_q  <= lane_a;
            r_pending <= (r_pending & ~w_gnt) | w_edge;
            r_drop    <= w_drop_next;
            if (w_load) begin
                if (w_arb_any) begin
                    r_valid  <= 1'b1;
                    r_lane   <= w_arb_idx;
                    r_rr_ptr <= w_rr_next;
                end else begin
                    r_valid  <= 1'b0;
                end
            end
        end
    end

`ifdef LANE_EVENT_COLLECTOR_TSTAMP_EN
    ts_t                r_ts_cnt;
    ts_t                r_ts [N_LANES];
    ts_t                r_evt_ts;
    logic [N_LANES-1:0] w_ts_cap;

    // Dropped edges keep the older timestamp of the still-pending event.
    assign w_ts_cap = w_edge & (~r_pending | w_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
            r_evt_ts <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                r_ts[i] <= '0;
            end
        end else begin
            r_ts_cnt <= r_ts_cnt + ts_t'(1);
            for (int i = 0; i < N_LANES; i++) begin
                if (w_ts_cap[i]) begin
                    r_ts[i] <= r_ts_cnt;
                end
            end
            if (w_load && w_arb_any) begin
                r_evt_ts <= r_ts[w_arb_idx];
            end
        end
    end

    assign evt_ts = r_evt_ts;
`endif

    assign evt_valid = r_valid;
    assign evt_lane  = r_lane;
    assign pending   = r_pending;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_lane_event_collector.sv
// Randomized bench for lane_event_collector against a behavioural model.
// Timestamps are also checked when LANE_EVENT_COLLECTOR_TSTAMP_EN is defined.
module tb_lane_event_collector;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] lane_a;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_lane;
    logic [N-1:0] pending;
    logic [DW-1:0] drop_cnt;
`ifdef LANE_EVENT_COLLECTOR_TSTAMP_EN
    logic [15:0]  evt_ts;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_prev [N];
    bit m_pend [N];
    int m_rr;
    bit m_valid;
    int m_lane;
    int m_drop;
    int m_ts_cnt;
    int m_ts [N];
    int m_evt_ts;

    lane_event_collector #(
        .N_LANES (N),
        .DROP_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lane_a    (lane_a),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_lane  (evt_lane),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
`ifdef LANE_EVENT_COLLECTOR_TSTAMP_EN
        ,
        .evt_ts    (evt_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_ts[i]   = 0;
        end
        m_rr = 0; m_valid = 0; m_lane = 0; m_drop = 0;
        m_ts_cnt = 0; m_evt_ts = 0;
    endtask

    task automatic model_step(input logic [N-1:0] a, input bit rdy);
        bit load;
        int g;
        int drops;
        bit e;
        bit np [N];
        load = !m_valid || rdy;
        g = -1;
        drops = 0;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        if (g >= 0) m_evt_ts = m_ts[g];
        for (int i = 0; i < N; i++) begin
            e = a[i] && !m_prev[i];
            if (e && m_pend[i] && i != g) drops++;
            if (e && (!m_pend[i] || i == g)) m_ts[i] = m_ts_cnt;
            np[i] = (m_pend[i] && i != g) || e;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = a[i];
        end
        if (load) begin
            if (g >= 0) begin
                m_valid = 1;
                m_lane  = g;
                m_rr    = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        m_drop   = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
        m_ts_cnt = (m_ts_cnt + 1) & 16'hFFFF;
    endtask

    function automatic int model_pend();
        int v;
        v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".valid"},   int'(evt_valid), int'(m_valid));
        check({tag, ".lane"},    int'(evt_lane),  m_lane);
        check({tag, ".pending"}, int'(pending),   model_pend());
        check({tag, ".drop"},    int'(drop_cnt),  m_drop);
`ifdef LANE_EVENT_COLLECTOR_TSTAMP_EN
        if (m_valid) check({tag, ".ts"}, int'(evt_ts), m_evt_ts);
`endif
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input string tag, input logic [N-1:0] a, input bit rdy);
        lane_a    = a;
        evt_ready = rdy;
        @(posedge clk);
        model_step(a, rdy);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; lane_a = '0; evt_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.valid", int'(evt_valid), 0);
        check("rst.drop",  int'(drop_cnt),  0);
        rst_n = 1'b1;

        // lane 2 edge: pending after E0, event after E1
        cyc("t1a", 4'b0100, 1'b1);
        check("t1.pend2", int'(pending), 4);
        cyc("t1b", 4'b0100, 1'b1);
        check("t1.lane2", int'(evt_lane), 2);
        check("t1.valid", int'(evt_valid), 1);
        check("t1.drained", int'(pending), 0);
        cyc("t1c", 4'b0000, 1'b1);
        cyc("t1d", 4'b0000, 1'b1);

        // all lanes at once
        cyc("t2", 4'b1111, 1'b1);
        repeat (6) cyc("t2", 4'b1111, 1'b1);
        check("t2.idle", int'(evt_valid), 0);
        cyc("t2", 4'b0000, 1'b1);

        // re-trigger under backpressure
        cyc("t3", 4'b0010, 1'b0);
        cyc("t3", 4'b0010, 1'b0);
        check("t3.lane1", int'(evt_lane), 1);
        cyc("t3", 4'b0000, 1'b0);
        cyc("t3", 4'b0010, 1'b0);
        cyc("t3", 4'b0000, 1'b0);
        cyc("t3", 4'b0010, 1'b0);
        check("t3.drop1", int'(drop_cnt), 1);
        check("t3.held", int'(evt_lane), 1);
        repeat (3) cyc("t3", 4'b0000, 1'b1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            cyc("rnd", N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        repeat (6) cyc("drain", 4'b0000, 1'b1);

        // saturate drop counter on lane 0
        for (int c = 0; c < 600; c++) begin
            cyc("sat", 4'b0001, 1'b0);
            cyc("sat", 4'b0000, 1'b0);
        end
        check("sat.max", int'(drop_cnt), DMAX);
        repeat (6) cyc("drain", 4'b0000, 1'b1);

        // mid-cycle asynchronous reset with work in flight
        cyc("t5", 4'b0010, 1'b0);
        cyc("t5", 4'b0010, 1'b0);
        cyc("t5", 4'b0000, 1'b0);
        cyc("t5", 4'b1010, 1'b0);
        check("t5.pend", int'(pending), 10);
        check("t5.valid", int'(evt_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t5.rst.valid", int'(evt_valid), 0);
        check("t5.rst.pend",  int'(pending),   0);
        check("t5.rst.drop",  int'(drop_cnt),  0);
        check("t5.rst.lane",  int'(evt_lane),  0);
        @(negedge clk);
        lane_a = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t5r", 4'b1010, 1'b1);
        cyc("t5r", 4'b1010, 1'b1);
        check("t5.first", int'(evt_lane), 1);
        cyc("t5r", 4'b1010, 1'b1);
        check("t5.second", int'(evt_lane), 3);
        cyc("t5r", 4'b1010, 1'b1);
        check("t5.done", int'(evt_valid), 0);

        // more random traffic after the reset
        for (int c = 0; c < 500; c++) begin
            cyc("rnd2", N'($urandom_range(0, 15)), $urandom_range(0, 1) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
